comparator_nbit_serial: RTL and testbench
=========================================

// Module: comparator_nbit_serial
// PURPOSE
//   Parametrised sequential magnitude comparator; successor to the fixed 4-bit combinational comparator.
//   Compares two WIDTH-bit operands CHUNK bits per cycle, MSB chunk first, unsigned or two's-complement.
//   Uses a start/busy/done handshake and holds registered gt/lt/eq flags until the next result.
//   Sits beside the datapath; lets wide compares avoid a long combinational carry chain.
// PARAMETERS
//   WIDTH      16  operand width in bits; must be a multiple of CHUNK
//   CHUNK       4  bits compared per cycle; NCHUNK = WIDTH/CHUNK
//   EARLY_EXIT  1  1: finish at the first unequal chunk; 0: always take NCHUNK cycles (fixed latency)
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   start      in   1      request; sampled only when busy=0
//   is_signed  in   1      1: two's-complement compare; 0: unsigned; latched with start
//   A          in   WIDTH  operand A; latched with start
//   B          in   WIDTH  operand B; latched with start
//   busy       out  1      compare in progress
//   done       out  1      one-cycle pulse; flags are valid from this cycle on
//   A_gt_B     out  1      A > B, registered
//   A_lt_B     out  1      A < B, registered
//   A_eq_B     out  1      A == B, registered
// BEHAVIOUR
//   - Reset (async assert, sync release): state=IDLE; busy, done, A_gt_B, A_lt_B and A_eq_B all 0.
//   - IDLE: at an edge with start=1, latch A, B and is_signed; set chunk index k=0 (MSB chunk).
//     Enter RUN with busy=1.
//   - RUN: each edge evaluates chunk k = bits [WIDTH-1-k*CHUNK -: CHUNK].
//   - Signed mode: in chunk 0 only, the MSB of each operand is inverted before an unsigned chunk compare.
//     This maps two's-complement ordering onto unsigned ordering.
//   - First unequal chunk fixes the result (gt or lt); later chunks cannot change it.
//   - EARLY_EXIT=1: on the first unequal chunk, register the flags and return to IDLE.
//   - EARLY_EXIT=0: keep stepping to k=NCHUNK-1; the decided result is frozen.
//   - After chunk NCHUNK-1 with no difference: eq.
//   - Completion edge: exactly one flag set; done=1 for one cycle; busy=0 in the same cycle.
//   - Latency (start edge to done cycle): k+1 cycles when exiting at chunk k; NCHUNK cycles when equal
//     or when EARLY_EXIT=0.
//   - Flags hold until the next completion. They do not change or clear during a new RUN.
//   - start while busy=1: ignored; the in-flight compare is unaffected.
//   - start in the done cycle: accepted (state is IDLE), giving back-to-back operation.
//   - A, B and is_signed changing while busy: no effect; only latched copies are used.
//   - rst_n low mid-RUN: abort immediately; flags cleared; no done pulse.
//   - Chunk index width is $clog2(NCHUNK), minimum 1. Compare NCHUNK-1 explicitly; no reliance on wrap.
//   - NCHUNK=1 (CHUNK=WIDTH): single-cycle RUN; latency 1.
// STRUCTURE
//   - comparator_pkg: state enum {IDLE, RUN}; result encoding {RES_EQ, RES_GT, RES_LT};
//     function nchunk(WIDTH, CHUNK).
//   - Sub-module comparator_chunk #(CHUNK): combinational CHUNK-bit gt/lt/eq slice, instantiated once
//     and fed by a k-indexed mux.
//   - Top level: FSM, latched operands, chunk counter, result/flag registers; elaboration check on
//     WIDTH % CHUNK.
// TESTING (WIDTH=16, CHUNK=4 unless noted)
//   1. Unsigned: A=0x1234, B=0x1234 -> eq=1, gt=lt=0; done 4 cycles after start; busy high 4 cycles.
//   2. A=0xC000, B=0x6000: unsigned -> gt, done after 1 cycle; signed -> lt, done after 1 cycle.
//   3. Unsigned: A=0x00A0, B=0x00A1 -> lt after 4 cycles.
//      EARLY_EXIT=0: A=0xF000, B=0x0000 -> gt after 4 cycles.
//   4. Signed: 0x8000 vs 0x7FFF -> lt; 0xFFFF vs 0xFFFF -> eq; 0xFFFE vs 0xFFFF -> lt.
//   5. start pulsed mid-RUN -> ignored, result unchanged. start in the done cycle -> second compare
//      begins; flags hold the old result until the new done.
//   6. rst_n low during RUN -> busy, done and all flags 0 asynchronously; no done;
//      a fresh start after release compares correctly.

Source files
------------

// File: rtl/comparator_pkg.sv
`default_nettype none
// ============================================================================
// comparator_pkg : shared FSM state, result encoding and chunk-count helper
// Revision 1.0
// ============================================================================
package comparator_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    RES_EQ = 2'd0,
    RES_GT = 2'd1,
    RES_LT = 2'd2
  } result_t;

  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage
`default_nettype wire

// File: rtl/comparator_chunk.sv
`default_nettype none
// ============================================================================
// comparator_chunk : combinational unsigned gt/lt/eq of one CHUNK-bit slice
// Revision 1.0
// ============================================================================
module comparator_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  assign gt = (a > b);
  assign lt = (a < b);
  assign eq = (a == b);

endmodule
`default_nettype wire

// File: rtl/comparator_nbit_serial.sv
`default_nettype none
// ============================================================================
// comparator_nbit_serial : WIDTH-bit magnitude compare, CHUNK bits/cycle, MSB first
// Revision 1.0
// ============================================================================
module comparator_nbit_serial
  import comparator_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int CHUNK      = 4,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             A_gt_B,
  output logic             A_lt_B,
  output logic             A_eq_B
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int NSLOT  = 1 << KW;
  localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

  generate
    if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_chunk
      $error("comparator_nbit_serial: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  state_t           state_q, state_d;
  result_t          res_q, res_d, res_now, chunk_res;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             sgn_q, sgn_d;
  logic [KW-1:0]    k_q, k_d;
  logic             gt_q, gt_d, lt_q, lt_d, eq_q, eq_d, done_q, done_d;

  // Slot table padded to a power of two so k indexes it at its natural width.
  logic [CHUNK-1:0] a_slot [NSLOT];
  logic [CHUNK-1:0] b_slot [NSLOT];
  logic [CHUNK-1:0] cmp_a, cmp_b;
  logic             c_gt, c_lt, c_eq;

  for (genvar i = 0; i < NSLOT; i++) begin : g_slot
    if (i < NCHUNK) begin : g_used
      assign a_slot[i] = a_q[WIDTH-1-i*CHUNK -: CHUNK];
      assign b_slot[i] = b_q[WIDTH-1-i*CHUNK -: CHUNK];
    end else begin : g_pad
      assign a_slot[i] = '0;
      assign b_slot[i] = '0;
    end
  end

  // Flipping the sign bits of the top chunk maps two's-complement order onto unsigned order.
  always_comb begin
    cmp_a = a_slot[k_q];
    cmp_b = b_slot[k_q];
    if (sgn_q && (k_q == '0)) begin
      cmp_a[CHUNK-1] = ~cmp_a[CHUNK-1];
      cmp_b[CHUNK-1] = ~cmp_b[CHUNK-1];
    end
  end

  comparator_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a  (cmp_a),
    .b  (cmp_b),
    .gt (c_gt),
    .lt (c_lt),
    .eq (c_eq)
  );

  always_comb begin
    unique case ({c_gt, c_lt, c_eq})
      3'b100:  chunk_res = RES_GT;
      3'b010:  chunk_res = RES_LT;
      default: chunk_res = RES_EQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      res_q   <= RES_EQ;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      k_q     <= '0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      k_q     <= k_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    k_d     = k_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    done_d  = 1'b0;
    // Once a chunk has differed the outcome is frozen for the rest of the run.
    res_now = (res_q == RES_EQ) ? chunk_res : res_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          sgn_d   = is_signed;
          k_d     = '0;
          res_d   = RES_EQ;
          state_d = RUN;
        end
      end
      RUN: begin
        if ((k_q == K_LAST) || (EARLY_EXIT && (res_now != RES_EQ))) begin
          state_d = IDLE;
          done_d  = 1'b1;
          gt_d    = (res_now == RES_GT);
          lt_d    = (res_now == RES_LT);
          eq_d    = (res_now == RES_EQ);
        end else begin
          k_d   = k_q + KW'(1);
          res_d = res_now;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy   = (state_q == RUN);
  assign done   = done_q;
  assign A_gt_B = gt_q;
  assign A_lt_B = lt_q;
  assign A_eq_B = eq_q;

endmodule
`default_nettype wire

// File: tb/tb_comparator_nbit_serial.sv
`default_nettype none
// ============================================================================
// tb_comparator_nbit_serial : directed vector table plus handshake/reset sequences
// Revision 1.0
// ============================================================================
module tb_comparator_nbit_serial;

  localparam logic [2:0] GT = 3'b100;
  localparam logic [2:0] LT = 3'b010;
  localparam logic [2:0] EQ = 3'b001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        is_sgn = 1'b0;
  logic [15:0] a_in = '0;
  logic [15:0] b_in = '0;
  logic [2:0]  start_v = '0;
  logic [2:0]  busy_v, done_v, gt_v, lt_v, eq_v;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // 0: early exit, 1: fixed latency, 2: single-chunk
  comparator_nbit_serial #(.WIDTH(16), .CHUNK(4), .EARLY_EXIT(1'b1)) dut_ee (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .is_signed(is_sgn), .A(a_in), .B(b_in),
    .busy(busy_v[0]), .done(done_v[0]), .A_gt_B(gt_v[0]), .A_lt_B(lt_v[0]), .A_eq_B(eq_v[0]));

  comparator_nbit_serial #(.WIDTH(16), .CHUNK(4), .EARLY_EXIT(1'b0)) dut_fx (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .is_signed(is_sgn), .A(a_in), .B(b_in),
    .busy(busy_v[1]), .done(done_v[1]), .A_gt_B(gt_v[1]), .A_lt_B(lt_v[1]), .A_eq_B(eq_v[1]));

  comparator_nbit_serial #(.WIDTH(16), .CHUNK(16), .EARLY_EXIT(1'b1)) dut_one (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .is_signed(is_sgn), .A(a_in), .B(b_in),
    .busy(busy_v[2]), .done(done_v[2]), .A_gt_B(gt_v[2]), .A_lt_B(lt_v[2]), .A_eq_B(eq_v[2]));

  typedef struct {
    int          d;
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic [2:0]  flags;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] flags_of(input int d);
    return {gt_v[d], lt_v[d], eq_v[d]};
  endfunction

  task automatic launch(input int d, input logic [15:0] a, input logic [15:0] b, input logic s);
    a_in       = a;
    b_in       = b;
    is_sgn     = s;
    start_v[d] = 1'b1;
    @(posedge clk);
    #1;
    start_v[d] = 1'b0;
  endtask

  task automatic wait_done(input int d, input int lat0, output int lat, output int bc);
    lat = lat0;
    bc  = 0;
    for (int n = 0; n < 20; n++) begin
      if (busy_v[d]) bc++;
      @(posedge clk);
      #1;
      lat++;
      if (done_v[d]) return;
    end
    lat = -1;
  endtask

  initial begin
    int lat, bc;

    vecs[0]  = '{0, 16'h1234, 16'h1234, 1'b0, EQ, 4};
    vecs[1]  = '{0, 16'hC000, 16'h6000, 1'b0, GT, 1};
    vecs[2]  = '{0, 16'hC000, 16'h6000, 1'b1, LT, 1};
    vecs[3]  = '{0, 16'h00A0, 16'h00A1, 1'b0, LT, 4};
    vecs[4]  = '{1, 16'hF000, 16'h0000, 1'b0, GT, 4};
    vecs[5]  = '{0, 16'h8000, 16'h7FFF, 1'b1, LT, 1};
    vecs[6]  = '{0, 16'hFFFF, 16'hFFFF, 1'b1, EQ, 4};
    vecs[7]  = '{0, 16'hFFFE, 16'hFFFF, 1'b1, LT, 4};
    vecs[8]  = '{0, 16'h0100, 16'h0200, 1'b0, LT, 2};
    vecs[9]  = '{1, 16'h8000, 16'h7FFF, 1'b1, LT, 4};
    vecs[10] = '{2, 16'hFFFF, 16'h0001, 1'b0, GT, 1};
    vecs[11] = '{2, 16'hFFFF, 16'h0001, 1'b1, LT, 1};
    vecs[12] = '{2, 16'h5555, 16'h5555, 1'b0, EQ, 1};
    vecs[13] = '{0, 16'h1230, 16'h1203, 1'b0, GT, 3};

    #2 rst_n = 1'b0;
    #1;
    chk("reset_state", {busy_v, done_v, gt_v, lt_v, eq_v}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 14; i++) begin
      launch(vecs[i].d, vecs[i].a, vecs[i].b, vecs[i].s);
      wait_done(vecs[i].d, 0, lat, bc);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_busy_cycles", i), bc, vecs[i].lat);
      chk($sformatf("v%0d_flags", i), flags_of(vecs[i].d), vecs[i].flags);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_done_pulse", i), done_v[vecs[i].d], 1'b0);
    end

    // Back-to-back: start raised in the done cycle is accepted; old flags hold meanwhile.
    launch(0, 16'h9000, 16'h1000, 1'b0);
    wait_done(0, 0, lat, bc);
    chk("b2b_first_latency", lat, 1);
    chk("b2b_first_flags", flags_of(0), GT);
    launch(0, 16'h1111, 16'h1112, 1'b0);
    chk("b2b_second_busy", busy_v[0], 1'b1);
    chk("b2b_flags_held", flags_of(0), GT);
    wait_done(0, 0, lat, bc);
    chk("b2b_second_latency", lat, 4);
    chk("b2b_second_flags", flags_of(0), LT);

    // start while busy is ignored and operand changes do not disturb the latched copies.
    launch(0, 16'h1235, 16'h1234, 1'b0);
    a_in       = 16'h0000;
    b_in       = 16'hF000;
    is_sgn     = 1'b1;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    chk("midrun_flags_held", flags_of(0), LT);
    wait_done(0, 1, lat, bc);
    chk("midrun_latency", lat, 4);
    chk("midrun_flags", flags_of(0), GT);
    @(posedge clk);
    #1;
    chk("midrun_no_restart", busy_v[0], 1'b0);

    // Reset mid-run aborts with no done and clears flags before any clock edge.
    launch(0, 16'h1234, 16'h1234, 1'b0);
    @(posedge clk);
    #1;
    chk("abort_busy_before", busy_v[0], 1'b1);
    rst_n = 1'b0;
    #1;
    chk("abort_async_clear", {busy_v[0], done_v[0], gt_v[0], lt_v[0], eq_v[0]}, 5'b0);
    for (int n = 0; n < 3; n++) begin
      @(posedge clk);
      #1;
      chk($sformatf("abort_no_done_%0d", n), {busy_v[0], done_v[0]}, 2'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_after_release", {busy_v[0], done_v[0], flags_of(0)}, 5'b0);
    launch(0, 16'hC000, 16'h6000, 1'b0);
    wait_done(0, 0, lat, bc);
    chk("post_reset_latency", lat, 1);
    chk("post_reset_flags", flags_of(0), GT);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
